// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus between the ALU/RS result path
// and the store/load buffer. Each source feeds a small FIFO; one head entry is
// granted per cycle and broadcast (ROB index + data) on registered cdb_* outputs.
// Optional feature macro: CDB_ROUND_ROBIN_EN
//   defined     -> round-robin between sources when both have entries (ALU first after reset)
//   not defined -> fixed priority, SLB wins whenever it has an entry
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              has_misbranch,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_robnum,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_full,
  input  logic              slb_valid,
  input  logic [ROB_W-1:0]  slb_robnum,
  input  logic [DATA_W-1:0] slb_data,
  output logic              slb_full,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_robnum,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src,
  output logic              overflow_err
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic          SRC_SLB  = 1'b1;

  logic [ROB_W-1:0]  alu_rob_q [QDEPTH];
  logic [DATA_W-1:0] alu_dat_q [QDEPTH];
  logic [ROB_W-1:0]  slb_rob_q [QDEPTH];
  logic [DATA_W-1:0] slb_dat_q [QDEPTH];

  logic [PW-1:0] alu_wr, alu_rd, slb_wr, slb_rd;
  logic [CW-1:0] alu_cnt, slb_cnt;
  logic          last_grant;

  logic live, alu_ne, slb_ne, sel_slb;
  logic alu_push, slb_push, alu_pop, slb_pop;

  assign alu_full = (alu_cnt == FULL_CNT);
  assign slb_full = (slb_cnt == FULL_CNT);

`ifndef CDB_ROUND_ROBIN_EN
  // last_grant is still tracked in fixed-priority builds but does not steer the grant.
  logic lg_unused;
  assign lg_unused = last_grant;
`endif

  // Grant selection and push/pop qualification, all from pre-edge state.
  always_comb begin
    live    = rdy & ~has_misbranch;
    alu_ne  = (alu_cnt != '0);
    slb_ne  = (slb_cnt != '0);
`ifdef CDB_ROUND_ROBIN_EN
    sel_slb = (alu_ne & slb_ne) ? (last_grant != SRC_SLB) : slb_ne;
`else
    sel_slb = slb_ne;
`endif
    // Push checks full before any same-edge pop, so a pop never makes room this edge.
    alu_push = live & alu_valid & ~alu_full;
    slb_push = live & slb_valid & ~slb_full;
    alu_pop  = live & alu_ne & ~sel_slb;
    slb_pop  = live & slb_ne & sel_slb;
  end

  // FIFO storage: entry data only, no reset needed.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_rob_q[alu_wr] <= alu_robnum;
      alu_dat_q[alu_wr] <= alu_data;
    end
    if (slb_push) begin
      slb_rob_q[slb_wr] <= slb_robnum;
      slb_dat_q[slb_wr] <= slb_data;
    end
  end

  // FIFO pointers/counts, broadcast register, grant history and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_wr       <= '0;
      alu_rd       <= '0;
      alu_cnt      <= '0;
      slb_wr       <= '0;
      slb_rd       <= '0;
      slb_cnt      <= '0;
      cdb_valid    <= 1'b0;
      cdb_robnum   <= '0;
      cdb_data     <= '0;
      cdb_src      <= 1'b0;
      last_grant   <= SRC_SLB;
      overflow_err <= 1'b0;
    end else if (rdy) begin
      if (has_misbranch) begin
        alu_wr    <= '0;
        alu_rd    <= '0;
        alu_cnt   <= '0;
        slb_wr    <= '0;
        slb_rd    <= '0;
        slb_cnt   <= '0;
        cdb_valid <= 1'b0;
      end else begin
        if (alu_push) alu_wr <= alu_wr + PW'(1);
        if (alu_pop)  alu_rd <= alu_rd + PW'(1);
        if (alu_push & ~alu_pop)      alu_cnt <= alu_cnt + CW'(1);
        else if (~alu_push & alu_pop) alu_cnt <= alu_cnt - CW'(1);

        if (slb_push) slb_wr <= slb_wr + PW'(1);
        if (slb_pop)  slb_rd <= slb_rd + PW'(1);
        if (slb_push & ~slb_pop)      slb_cnt <= slb_cnt + CW'(1);
        else if (~slb_push & slb_pop) slb_cnt <= slb_cnt - CW'(1);

        if ((alu_valid & alu_full) | (slb_valid & slb_full))
          overflow_err <= 1'b1;

        if (alu_ne | slb_ne) begin
          cdb_valid  <= 1'b1;
          cdb_src    <= sel_slb;
          cdb_robnum <= sel_slb ? slb_rob_q[slb_rd] : alu_rob_q[alu_rd];
          cdb_data   <= sel_slb ? slb_dat_q[slb_rd] : alu_dat_q[alu_rd];
          last_grant <= sel_slb;
        end else begin
          cdb_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: table-driven vectors plus a queue-based
// reference model that is updated on every clock edge and compared every cycle.
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, has_misbranch;
  logic          alu_valid, slb_valid;
  logic [RW-1:0] alu_robnum, slb_robnum;
  logic [DW-1:0] alu_data, slb_data;
  logic          alu_full, slb_full;
  logic          cdb_valid, cdb_src, overflow_err;
  logic [RW-1:0] cdb_robnum;
  logic [DW-1:0] cdb_data;

  cdb_arbiter #(.DATA_W(DW), .ROB_W(RW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .alu_valid(alu_valid), .alu_robnum(alu_robnum), .alu_data(alu_data), .alu_full(alu_full),
    .slb_valid(slb_valid), .slb_robnum(slb_robnum), .slb_data(slb_data), .slb_full(slb_full),
    .cdb_valid(cdb_valid), .cdb_robnum(cdb_robnum), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] rob;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model state
  ent_t          aq[$];
  ent_t          sq[$];
  logic          m_cv, m_csrc, m_lg, m_ovf;
  logic [RW-1:0] m_crob;
  logic [DW-1:0] m_cdata;
  int            m_acc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    sq.delete();
    m_cv = 0; m_csrc = 0; m_crob = '0; m_cdata = '0; m_lg = 1'b1; m_ovf = 0;
  endtask

  task automatic model_edge();
    logic a_ne, s_ne, a_full, s_full, win;
    ent_t e;
    if (rst) begin model_reset(); return; end
    if (!rdy) return;
    if (has_misbranch) begin
      aq.delete(); sq.delete(); m_cv = 0;
      return;
    end
    a_ne   = (aq.size() > 0);
    s_ne   = (sq.size() > 0);
    a_full = (aq.size() == QD);
    s_full = (sq.size() == QD);
`ifdef CDB_ROUND_ROBIN_EN
    win = (a_ne && s_ne) ? ~m_lg : s_ne;
`else
    win = s_ne;
`endif
    if (a_ne || s_ne) begin
      if (win) e = sq.pop_front();
      else     e = aq.pop_front();
      m_cv = 1; m_crob = e.rob; m_cdata = e.data; m_csrc = win; m_lg = win;
    end else begin
      m_cv = 0;
    end
    if (alu_valid) begin
      if (a_full) m_ovf = 1;
      else begin aq.push_back('{alu_robnum, alu_data}); m_acc++; end
    end
    if (slb_valid) begin
      if (s_full) m_ovf = 1;
      else begin sq.push_back('{slb_robnum, slb_data}); m_acc++; end
    end
  endtask

  task automatic compare_model();
    chk("cdb_valid", cdb_valid, m_cv);
    chk("cdb_robnum", cdb_robnum, m_crob);
    chk("cdb_data", cdb_data, m_cdata);
    chk("cdb_src", cdb_src, m_csrc);
    chk("alu_full", alu_full, aq.size() == QD);
    chk("slb_full", slb_full, sq.size() == QD);
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    alu_valid = 0; slb_valid = 0; has_misbranch = 0; rdy = 1;
    alu_robnum = '0; alu_data = '0; slb_robnum = '0; slb_data = '0;
  endtask

  task automatic drive(input logic av, input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                       input logic sv, input logic [RW-1:0] sr, input logic [DW-1:0] sd);
    alu_valid = av; alu_robnum = ar; alu_data = ad;
    slb_valid = sv; slb_robnum = sr; slb_data = sd;
  endtask

  typedef struct packed {
    logic          av;
    logic [RW-1:0] arob;
    logic [DW-1:0] adat;
    logic          sv;
    logic [RW-1:0] srob;
    logic [DW-1:0] sdat;
    logic          mis;
    logic          rdy;
    logic          ev;
    logic [RW-1:0] erob;
    logic [DW-1:0] edat;
    logic          esrc;
  } vec_t;

  vec_t vt[11];
  int   nb;

  initial begin
    // av arob adat          sv srob sdat    mis rdy  ev erob edat          esrc
    vt[0]  = '{1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 0, 1, 0, 4'd0, 32'h0, 0};
`ifdef CDB_ROUND_ROBIN_EN
    vt[1]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 1, 4'd1, 32'hA, 0};
    vt[2]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 1, 4'd2, 32'hB, 1};
`else
    vt[1]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 1, 4'd2, 32'hB, 1};
    vt[2]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 1, 4'd1, 32'hA, 0};
`endif
    vt[3]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'd0, 32'h0, 0};
    vt[4]  = '{1, 4'd3, 32'h12345678, 0, 4'd0, 32'h0, 0, 1, 0, 4'd0, 32'h0, 0};
    vt[5]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 1, 4'd3, 32'h12345678, 0};
    vt[6]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'd0, 32'h0, 0};
    vt[7]  = '{1, 4'd5, 32'h55, 0, 4'd0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 0};
    vt[8]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'd0, 32'h0, 0};
    vt[9]  = '{1, 4'd6, 32'h66, 1, 4'd7, 32'h77, 1, 1, 0, 4'd0, 32'h0, 0};
    vt[10] = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 1, 0, 4'd0, 32'h0, 0};

    rst = 1;
    idle_inputs();
    model_reset();
    m_acc = 0;
    step();
    step();
    rst = 0;
    step();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].av, vt[i].arob, vt[i].adat, vt[i].sv, vt[i].srob, vt[i].sdat);
      has_misbranch = vt[i].mis;
      rdy = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), cdb_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_rob", i), cdb_robnum, vt[i].erob);
        chk($sformatf("vec%0d_data", i), cdb_data, vt[i].edat);
        chk($sformatf("vec%0d_src", i), cdb_src, vt[i].esrc);
      end
    end
    idle_inputs();
    step();

    // Saturating traffic: both sources push every edge, one FIFO fills and overflows
    m_acc = 0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, RW'(i), 32'hA000_0000 + i, 1, RW'(i + 8), 32'hB000_0000 + i);
      step();
      if (cdb_valid) nb++;
    end
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      step();
      if (cdb_valid) nb++;
    end
    chk("sat_overflow_err", overflow_err, 1'b1);
    chk("sat_broadcast_count", nb, m_acc);

    // Misbranch flush with entries queued and concurrent pushes
    drive(1, 4'd1, 32'hF1, 1, 4'd9, 32'hF9);
    step();
    drive(1, 4'd2, 32'hF2, 1, 4'd10, 32'hFA);
    step();
    drive(1, 4'd3, 32'hF3, 1, 4'd11, 32'hFB);
    has_misbranch = 1;
    step();
    chk("flush_valid", cdb_valid, 1'b0);
    chk("flush_alu_full", alu_full, 1'b0);
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("flush_no_bcast", cdb_valid, 1'b0);
    end

    // rdy low with a broadcast pending and two entries queued
    drive(1, 4'd1, 32'hC1, 1, 4'd8, 32'hD8);
    step();
    drive(1, 4'd2, 32'hC2, 0, 4'd0, 32'h0);
    step();
    drive(1, 4'd3, 32'hC3, 0, 4'd0, 32'h0);
    step();
    chk("frz_pre_valid", cdb_valid, 1'b1);
    drive(1, 4'd4, 32'hC4, 1, 4'd12, 32'hDC);
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_valid_held", cdb_valid, 1'b1);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset mid-traffic with three entries queued
    drive(1, 4'd1, 32'hE1, 1, 4'd9, 32'hE9);
    step();
    drive(1, 4'd2, 32'hE2, 1, 4'd10, 32'hEA);
    step();
    idle_inputs();
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_robnum", cdb_robnum, 4'd0);
    chk("rst_cdb_data", cdb_data, 32'd0);
    chk("rst_cdb_src", cdb_src, 1'b0);
    chk("rst_alu_full", alu_full, 1'b0);
    chk("rst_slb_full", slb_full, 1'b0);
    chk("rst_overflow_err", overflow_err, 1'b0);
    step();
    rst = 0;
    step();
    drive(1, 4'd3, 32'h12345678, 0, 4'd0, 32'h0);
    step();
    idle_inputs();
    step();
    chk("post_rst_valid", cdb_valid, 1'b1);
    chk("post_rst_rob", cdb_robnum, 4'd3);
    chk("post_rst_data", cdb_data, 32'h12345678);
    step();
    chk("post_rst_idle", cdb_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
